// File: rtl/acc_12bit_v.sv
// 12-bit accumulator with a valid/ready command port.
// Commands (LOAD, ADD, SUB, CLEAR) are accepted in IDLE, executed in EXEC and
// acknowledged with a one-cycle done pulse in DONE. All arithmetic goes through a
// single ripple-carry adder; subtraction uses A + ~B + 1.

// 12-bit ripple-carry adder: sum_o = a_i + b_i + cin_i, cout_o is the carry out of bit 11.
module rca_12bit_v (
    input  logic [11:0] a_i,
    input  logic [11:0] b_i,
    input  logic        cin_i,
    output logic [11:0] sum_o,
    output logic        cout_o
);

    // Bit-serial carry chain. A single local carry variable keeps the chain
    // acyclic from the simulator's point of view.
    always_comb begin
        logic carry;
        carry  = cin_i;
        sum_o  = '0;
        for (int i = 0; i < 12; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

module acc_12bit_v (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [1:0]  i_op,
    input  logic [11:0] i_data,
    output logic [11:0] o_acc,
    output logic        o_carry,
    output logic        o_ovf,
    output logic        o_done,
    output logic [7:0]  o_cnt
);

    localparam logic [1:0] OpLoad  = 2'b00;
    localparam logic [1:0] OpAdd   = 2'b01;
    localparam logic [1:0] OpSub   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [11:0] data_q, data_d;
    logic [11:0] acc_q, acc_d;
    logic        carry_q, carry_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [11:0] rca_b;
    logic        rca_cin;
    logic [11:0] rca_sum;
    logic        rca_cout;
    logic        rca_ovf;
    logic        is_sub;

    // Adder operand selection from the captured command; inputs after capture are irrelevant.
    always_comb begin
        is_sub  = (op_q == OpSub);
        rca_b   = is_sub ? ~data_q : data_q;
        rca_cin = is_sub;
    end

    rca_12bit_v u_rca (
        .a_i    (acc_q),
        .b_i    (rca_b),
        .cin_i  (rca_cin),
        .sum_o  (rca_sum),
        .cout_o (rca_cout)
    );

    // Signed overflow uses the operand actually applied to the adder (inverted for SUB).
    always_comb begin
        rca_ovf = (acc_q[11] == rca_b[11]) && (rca_sum[11] != acc_q[11]);
    end

    // Next-state and datapath updates for the IDLE -> EXEC -> DONE sequence.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                // Requests are only taken here; anything offered while busy is dropped.
                if (i_valid) begin
                    op_d    = i_op;
                    data_d  = i_data;
                    state_d = StExec;
                end
            end
            StExec: begin
                unique case (op_q)
                    OpLoad: begin
                        acc_d   = data_q;
                        carry_d = 1'b0;
                        ovf_d   = 1'b0;
                    end
                    OpAdd, OpSub: begin
                        acc_d   = rca_sum;
                        carry_d = rca_cout;
                        ovf_d   = rca_ovf;
                    end
                    OpClear: begin
                        acc_d   = '0;
                        carry_d = 1'b0;
                        ovf_d   = 1'b0;
                    end
                    default: begin
                        acc_d = acc_q;
                    end
                endcase
                cnt_d   = cnt_q + 8'd1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; synchronous reset wins over any accept or execute.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            data_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are straight decodes of registered state.
    always_comb begin
        o_ready = (state_q == StIdle);
        o_done  = (state_q == StDone);
        o_acc   = acc_q;
        o_carry = carry_q;
        o_ovf   = ovf_q;
        o_cnt   = cnt_q;
    end

endmodule

// File: tb/tb_acc_12bit_v.sv
// Directed bench for acc_12bit_v with a cycle-level arithmetic reference model.
module tb_acc_12bit_v;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [1:0]  op;
    logic [11:0] data;
    logic [11:0] acc;
    logic        carry;
    logic        ovf;
    logic        done;
    logic [7:0]  cnt;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    acc_12bit_v dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .o_ready (ready),
        .i_op    (op),
        .i_data  (data),
        .o_acc   (acc),
        .o_carry (carry),
        .o_ovf   (ovf),
        .o_done  (done),
        .o_cnt   (cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase counts cycles since accept (0 = idle/ready).
    int          m_phase;
    logic [11:0] m_acc;
    logic        m_carry;
    logic        m_ovf;
    logic [7:0]  m_cnt;
    logic [1:0]  m_op;
    logic [11:0] m_data;
    bit          m_live = 0;

    function automatic int to_signed12(input logic [11:0] v);
        return (int'(v) >= 2048) ? int'(v) - 4096 : int'(v);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_acc   = '0;
            m_carry = 1'b0;
            m_ovf   = 1'b0;
            m_cnt   = '0;
            m_op    = '0;
            m_data  = '0;
            m_live  = 1;
        end else if (m_live) begin
            if (m_phase == 0) begin
                if (valid) begin
                    m_op    = op;
                    m_data  = data;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                int sum;
                int sres;
                case (m_op)
                    2'b00: begin
                        m_acc = m_data; m_carry = 1'b0; m_ovf = 1'b0;
                    end
                    2'b01: begin
                        sum     = int'(m_acc) + int'(m_data);
                        sres    = to_signed12(m_acc) + to_signed12(m_data);
                        m_carry = (sum > 4095);
                        m_ovf   = (sres > 2047) || (sres < -2048);
                        m_acc   = sum[11:0];
                    end
                    2'b10: begin
                        sres    = to_signed12(m_acc) - to_signed12(m_data);
                        m_carry = (m_acc >= m_data);
                        m_ovf   = (sres > 2047) || (sres < -2048);
                        m_acc   = m_acc - m_data;
                    end
                    default: begin
                        m_acc = '0; m_carry = 1'b0; m_ovf = 1'b0;
                    end
                endcase
                m_cnt   = m_cnt + 8'd1;
                m_phase = 2;
            end else begin
                m_phase = 0;
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_live) begin
            check("ready", ready, m_phase == 0);
            check("done",  done,  m_phase == 2);
            check("acc",   acc,   m_acc);
            check("carry", carry, m_carry);
            check("ovf",   ovf,   m_ovf);
            check("cnt",   cnt,   m_cnt);
        end
    end

    // Issue one command from idle and check the 0,1,0 done pattern; garbles inputs after capture.
    task automatic do_cmd(input logic [1:0] c_op, input logic [11:0] c_data);
        valid = 1'b1;
        op    = c_op;
        data  = c_data;
        @(negedge clk);
        check("cmd_busy_after_accept", ready, 1'b0);
        check("cmd_done_exec", done, 1'b0);
        valid = 1'b0;
        op    = 2'($urandom);
        data  = 12'($urandom);
        @(negedge clk);
        check("cmd_done_pulse", done, 1'b1);
        @(negedge clk);
        check("cmd_done_end", done, 1'b0);
        check("cmd_ready_again", ready, 1'b1);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int seen;
        int pos[$];

        // Reset held two cycles while a request is offered.
        rst   = 1'b1;
        valid = 1'b1;
        op    = 2'b01;
        data  = 12'h005;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        check("rst_acc", acc, 12'h000);
        check("rst_carry", carry, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_cnt", cnt, 8'd0);
        check("rst_done", done, 1'b0);
        check("rst_ready", ready, 1'b1);

        // Signed overflow.
        do_cmd(2'b00, 12'h7FF);
        do_cmd(2'b01, 12'h001);
        check("ovf_acc", acc, 12'h800);
        check("ovf_carry", carry, 1'b0);
        check("ovf_ovf", ovf, 1'b1);
        check("ovf_cnt", cnt, 8'd2);

        // Unsigned wrap.
        do_cmd(2'b00, 12'hFFF);
        do_cmd(2'b01, 12'h001);
        check("wrap_acc", acc, 12'h000);
        check("wrap_carry", carry, 1'b1);
        check("wrap_ovf", ovf, 1'b0);

        // Subtract with borrow, then without.
        do_cmd(2'b00, 12'h005);
        do_cmd(2'b10, 12'h007);
        check("sub1_acc", acc, 12'hFFE);
        check("sub1_carry", carry, 1'b0);
        check("sub1_ovf", ovf, 1'b0);
        do_cmd(2'b10, 12'hFFE);
        check("sub2_acc", acc, 12'h000);
        check("sub2_carry", carry, 1'b1);

        // Busy rejection: valid held for 9 cycles.
        do_reset();
        valid = 1'b1;
        op    = 2'b01;
        data  = 12'h001;
        seen  = 0;
        for (int i = 0; i < 9; i++) begin
            if (ready) begin
                seen++;
                pos.push_back(i);
            end
            @(negedge clk);
        end
        valid = 1'b0;
        check("busy_accepts", seen, 3);
        if (pos.size() == 3) begin
            check("busy_spacing1", pos[1] - pos[0], 3);
            check("busy_spacing2", pos[2] - pos[1], 3);
        end
        check("busy_acc", acc, 12'h003);
        check("busy_cnt", cnt, 8'd3);
        do_cmd(2'b11, 12'hABC);
        check("clear_acc", acc, 12'h000);
        check("clear_carry", carry, 1'b0);
        check("clear_ovf", ovf, 1'b0);
        check("clear_cnt", cnt, 8'd4);

        // Reset during EXEC discards the command.
        do_cmd(2'b00, 12'h100);
        valid = 1'b1;
        op    = 2'b01;
        data  = 12'h010;
        @(negedge clk);
        check("midrst_accepted", ready, 1'b0);
        valid = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_acc", acc, 12'h000);
        check("midrst_cnt", cnt, 8'd0);
        check("midrst_done", done, 1'b0);
        @(negedge clk);
        check("midrst_done_later", done, 1'b0);
        check("midrst_ready", ready, 1'b1);

        // Count wrap: 256 commands from zero return o_cnt to 0.
        for (int i = 0; i < 256; i++) begin
            do_cmd(2'b00, 12'(i));
        end
        check("cntwrap_cnt", cnt, 8'd0);
        check("cntwrap_acc", acc, 12'h0FF);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
